fact_err_status_bank: RTL and testbench
=======================================

Name: fact_err_status_bank

Overview:
Parametrised multi-channel sticky error/status register bank. It generalises the single-bit sticky result-error flag used by the factorial accelerator wrapper to NUM_CH channels. Each channel adds optional edge-mode capture, per-channel write-1-to-clear, first-error capture, a saturating error-event counter and a maskable registered interrupt. It sits between the accelerator datapath error sources and the memory-mapped status/IO interface; GoPulseCmb (start of a new job) clears all state.

Parameters:
NUM_CH, 4, number of error channels (2..32)
CNT_W, 8, width of saturating error-event counter (1..16)
EDGE_MODE, 0, 0 = channel sets on Err level high; 1 = sets only on Err rising edge
ID_W, $clog2(NUM_CH), width of first-error index (derived; not overridden)

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  reset; synchronous, active-high
GoPulseCmb  in  1  global clear, one-cycle pulse at job start
Err  in  NUM_CH  raw per-channel error inputs
ClrWe  in  1  write strobe for per-channel clear
ClrMask  in  NUM_CH  write-1-to-clear bits, qualified by ClrWe
IntEn  in  NUM_CH  per-channel interrupt enable
ResErr  out  NUM_CH  sticky per-channel error flags (registered)
AnyErr  out  1  OR of ResErr (combinational from registers)
FirstErrValid  out  1  first-error capture valid (registered)
FirstErrId  out  ID_W  index of first channel to flag since last clear (registered)
ErrCnt  out  CNT_W  saturating count of error-event cycles (registered)
Irq  out  1  registered interrupt

Behaviour:
- Reset (Rst=1 at a rising edge): ResErr=0, FirstErrValid=0, FirstErrId=0, ErrCnt=0, Irq=0, internal ErrD=0. Rst overrides all other inputs. Reset mid-operation discards all state in that cycle.
- Event vector Ev: EDGE_MODE=0 -> Ev=Err; EDGE_MODE=1 -> Ev=Err & ~ErrD. ErrD<=Err every non-reset cycle, including GoPulseCmb cycles.
- GoPulseCmb=1 (Rst=0): ResErr, FirstErrValid, FirstErrId, ErrCnt all <=0 next cycle. Events in that cycle are ignored, and the clear wins, as in the single-bit version.
- Otherwise, per channel i: ResErr[i] <= Ev[i] | (ResErr[i] & ~(ClrWe & ClrMask[i])). A set and a clear on the same channel in the same cycle give set.
- ClrMask is ignored when ClrWe=0. W1C does not affect FirstErr* or ErrCnt.
- First-error capture: if FirstErrValid=0 and |Ev, then FirstErrValid<=1 and FirstErrId<=lowest index i with Ev[i]=1. Once valid, it holds until GoPulseCmb or Rst. New events and W1C do not change it.
- ErrCnt: +1 on each cycle with |Ev=1, not per channel. It saturates at 2^CNT_W-1 with no wrap.
- Irq <= |(ResErr & IntEn), using the current registered ResErr. Irq therefore lags ResErr by one cycle, so an event sets Irq two edges later. Irq drops one cycle after the enabled bits clear or IntEn deasserts.
- AnyErr = |ResErr, with no added latency.
- Latency: event at edge N is visible on ResErr, FirstErr*, ErrCnt after edge N; on Irq after edge N+1.

Test Plan:
- Reset: hold Rst 2 cycles with Err=4'hF, GoPulseCmb=0 -> all outputs 0 after each edge; after release with Err=4'hF, level mode -> ResErr=4'hF, ErrCnt=1, FirstErrId=0.
- Simultaneous set/first capture: NUM_CH=4, EDGE_MODE=0, Err=4'b1010 one cycle -> ResErr=4'b1010, FirstErrId=1, FirstErrValid=1, ErrCnt=1; then Err=4'b0001 -> ResErr=4'b1011, FirstErrId stays 1, ErrCnt=2.
- W1C vs set: ResErr=4'b0110, ClrWe=1, ClrMask=4'b0110, Err=4'b0100 same cycle -> ResErr=4'b0100; ClrWe=1 with ClrMask=4'b1111 but ClrWe=0 next -> verify only the strobed cycle clears.
- Global clear priority: ResErr=4'hF, ErrCnt=9, GoPulseCmb=1 with Err=4'hF -> ResErr=0, ErrCnt=0, FirstErrValid=0. The next cycle with Err still high (level) -> ResErr=4'hF, ErrCnt=1.
- Edge mode + saturation: EDGE_MODE=1, CNT_W=2, Err[0] held high 5 cycles -> ErrCnt=1 only. Toggle Err[0] 0/1 five times -> ErrCnt saturates at 3, with no wrap.
- Interrupt masking: IntEn=4'b0001, Err=4'b0010 -> Irq stays 0. Set IntEn=4'b0010 -> Irq=1 one cycle later. W1C channel 1 -> Irq=0 one cycle after ResErr[1] falls.

Source files
------------

// File: rtl/fact_err_status_bank.sv
// Multi-channel sticky error/status bank: per-channel sticky flags with W1C,
// first-error capture, saturating event counter and a maskable interrupt.
module fact_err_status_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = 0,
  parameter int ID_W      = $clog2(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              GoPulseCmb,
  input  logic [NUM_CH-1:0] Err,
  input  logic              ClrWe,
  input  logic [NUM_CH-1:0] ClrMask,
  input  logic [NUM_CH-1:0] IntEn,
  output logic [NUM_CH-1:0] ResErr,
  output logic              AnyErr,
  output logic              FirstErrValid,
  output logic [ID_W-1:0]   FirstErrId,
  output logic [CNT_W-1:0]  ErrCnt,
  output logic              Irq
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CH-1:0] err_d;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] clr_bits;
  logic              any_ev;
  logic [ID_W-1:0]   low_id;

  // Edge mode only reports the cycle a raw error rises.
  assign ev       = (EDGE_MODE != 0) ? (Err & ~err_d) : Err;
  assign any_ev   = |ev;
  assign clr_bits = ClrWe ? ClrMask : '0;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    low_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev[i]) low_id = ID_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_d         <= '0;
      ResErr        <= '0;
      FirstErrValid <= 1'b0;
      FirstErrId    <= '0;
      ErrCnt        <= '0;
      Irq           <= 1'b0;
    end else begin
      err_d <= Err;
      Irq   <= |(ResErr & IntEn);
      if (GoPulseCmb) begin
        ResErr        <= '0;
        FirstErrValid <= 1'b0;
        FirstErrId    <= '0;
        ErrCnt        <= '0;
      end else begin
        // A set wins over a same-cycle clear on the same channel.
        ResErr <= ev | (ResErr & ~clr_bits);
        if (!FirstErrValid && any_ev) begin
          FirstErrValid <= 1'b1;
          FirstErrId    <= low_id;
        end
        if (any_ev && (ErrCnt != CntMax)) ErrCnt <= ErrCnt + 1'b1;
      end
    end
  end

  assign AnyErr = |ResErr;

endmodule

// File: tb/tb_fact_err_status_bank.sv
// Randomised + directed bench for fact_err_status_bank: a level-mode and an
// edge-mode (2-bit counter) instance share stimulus and are scored against a model.
module tb_fact_err_status_bank;

  logic       Clk = 1'b0;
  logic       Rst, GoPulseCmb, ClrWe;
  logic [3:0] Err, ClrMask, IntEn;

  logic [3:0] l_res, e_res;
  logic       l_any, e_any, l_valid, e_valid, l_irq, e_irq;
  logic [1:0] l_id, e_id;
  logic [7:0] l_cnt;
  logic [1:0] e_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  fact_err_status_bank #(.NUM_CH(4), .CNT_W(8), .EDGE_MODE(0)) u_lvl (
    .Clk(Clk), .Rst(Rst), .GoPulseCmb(GoPulseCmb), .Err(Err), .ClrWe(ClrWe),
    .ClrMask(ClrMask), .IntEn(IntEn), .ResErr(l_res), .AnyErr(l_any),
    .FirstErrValid(l_valid), .FirstErrId(l_id), .ErrCnt(l_cnt), .Irq(l_irq));

  fact_err_status_bank #(.NUM_CH(4), .CNT_W(2), .EDGE_MODE(1)) u_edg (
    .Clk(Clk), .Rst(Rst), .GoPulseCmb(GoPulseCmb), .Err(Err), .ClrWe(ClrWe),
    .ClrMask(ClrMask), .IntEn(IntEn), .ResErr(e_res), .AnyErr(e_any),
    .FirstErrValid(e_valid), .FirstErrId(e_id), .ErrCnt(e_cnt), .Irq(e_irq));

  // Reference model, index 0 = level instance, index 1 = edge instance.
  bit m_res   [2][4];
  bit m_errd  [2][4];
  bit m_valid [2];
  int m_id    [2];
  int m_cnt   [2];
  bit m_irq   [2];
  int cnt_max [2] = '{255, 3};
  bit is_edge [2] = '{1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit ev [4];
      bit fired = 0;
      int first = -1;
      bit irq_next = 0;
      if (Rst) begin
        for (int i = 0; i < 4; i++) begin m_res[k][i] = 0; m_errd[k][i] = 0; end
        m_valid[k] = 0; m_id[k] = 0; m_cnt[k] = 0; m_irq[k] = 0;
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        ev[i] = Err[i] && !(is_edge[k] && m_errd[k][i]);
        if (ev[i]) begin
          fired = 1;
          if (first < 0) first = i;
        end
        if (m_res[k][i] && IntEn[i]) irq_next = 1;
      end
      if (GoPulseCmb) begin
        for (int i = 0; i < 4; i++) m_res[k][i] = 0;
        m_valid[k] = 0; m_id[k] = 0; m_cnt[k] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (ev[i]) m_res[k][i] = 1;
          else if (ClrWe && ClrMask[i]) m_res[k][i] = 0;
        end
        if (fired && !m_valid[k]) begin m_valid[k] = 1; m_id[k] = first; end
        if (fired && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end
      for (int i = 0; i < 4; i++) m_errd[k][i] = Err[i];
      m_irq[k] = irq_next;
    end
  endtask

  function automatic logic [3:0] exp_res(input int k);
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = m_res[k][i];
    return v;
  endfunction

  task automatic compare_all();
    check("lvl_res",   l_res,   exp_res(0));
    check("lvl_any",   l_any,   |exp_res(0));
    check("lvl_valid", l_valid, m_valid[0]);
    check("lvl_id",    l_id,    m_id[0]);
    check("lvl_cnt",   l_cnt,   m_cnt[0]);
    check("lvl_irq",   l_irq,   m_irq[0]);
    check("edg_res",   e_res,   exp_res(1));
    check("edg_any",   e_any,   |exp_res(1));
    check("edg_valid", e_valid, m_valid[1]);
    check("edg_id",    e_id,    m_id[1]);
    check("edg_cnt",   e_cnt,   m_cnt[1]);
    check("edg_irq",   e_irq,   m_irq[1]);
  endtask

  // One clock: inputs already driven, model advances at the edge, outputs checked 1ns later.
  task automatic step(input logic rst, input logic go, input logic [3:0] err,
                      input logic clr_we, input logic [3:0] mask, input logic [3:0] ien);
    Rst = rst; GoPulseCmb = go; Err = err; ClrWe = clr_we; ClrMask = mask; IntEn = ien;
    @(posedge Clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    Rst = 1'b1; GoPulseCmb = 1'b0; Err = '0; ClrWe = 1'b0; ClrMask = '0; IntEn = '0;

    // Reset dominates active errors.
    step(1, 0, 4'hF, 0, 4'h0, 4'h0);
    step(1, 0, 4'hF, 0, 4'h0, 4'h0);
    check("rst_res_zero", l_res, 4'h0);
    step(0, 0, 4'hF, 0, 4'h0, 4'h0);
    check("post_rst_res", l_res, 4'hF);
    check("post_rst_cnt", l_cnt, 8'd1);
    check("post_rst_id",  l_id,  2'd0);

    // Simultaneous set and first-error capture.
    step(0, 1, 4'h0, 0, 4'h0, 4'h0);
    step(0, 0, 4'b1010, 0, 4'h0, 4'h0);
    check("first_id", l_id, 2'd1);
    step(0, 0, 4'b0001, 0, 4'h0, 4'h0);
    check("sticky_res", l_res, 4'b1011);
    check("first_hold", l_id, 2'd1);
    check("cnt_two",    l_cnt, 8'd2);

    // W1C against a same-cycle set, then strobe qualification.
    step(0, 1, 4'h0, 0, 4'h0, 4'h0);
    step(0, 0, 4'b0110, 0, 4'h0, 4'h0);
    step(0, 0, 4'b0100, 1, 4'b0110, 4'h0);
    check("w1c_vs_set", l_res, 4'b0100);
    step(0, 0, 4'h0, 1, 4'hF, 4'h0);
    check("w1c_all", l_res, 4'h0);
    step(0, 0, 4'hF, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 0, 4'hF, 4'h0);
    check("mask_no_strobe", l_res, 4'hF);

    // Global clear beats a same-cycle event.
    step(0, 1, 4'h0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 9; i++) step(0, 0, 4'hF, 0, 4'h0, 4'h0);
    check("cnt_nine", l_cnt, 8'd9);
    step(0, 1, 4'hF, 0, 4'h0, 4'h0);
    check("go_clears_cnt", l_cnt, 8'd0);
    step(0, 0, 4'hF, 0, 4'h0, 4'h0);
    check("go_then_level", l_cnt, 8'd1);
    check("go_edge_quiet", e_res, 4'h0);

    // Edge detection and counter saturation.
    step(0, 1, 4'h0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 4'b0001, 0, 4'h0, 4'h0);
    check("edge_held_cnt", e_cnt, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'b0000, 0, 4'h0, 4'h0);
      step(0, 0, 4'b0001, 0, 4'h0, 4'h0);
    end
    check("edge_sat_cnt", e_cnt, 2'd3);

    // Interrupt masking and one-cycle lag.
    step(0, 1, 4'h0, 0, 4'h0, 4'h0);
    step(0, 0, 4'b0010, 0, 4'h0, 4'b0001);
    step(0, 0, 4'b0000, 0, 4'h0, 4'b0001);
    step(0, 0, 4'b0000, 0, 4'h0, 4'b0001);
    check("irq_masked", l_irq, 1'b0);
    step(0, 0, 4'b0000, 0, 4'h0, 4'b0010);
    check("irq_enabled", l_irq, 1'b1);
    step(0, 0, 4'b0000, 1, 4'b0010, 4'b0010);
    check("irq_lag", l_irq, 1'b1);
    step(0, 0, 4'b0000, 0, 4'h0, 4'b0010);
    check("irq_drop", l_irq, 1'b0);

    // Random traffic: errors mostly sparse so first-capture and W1C interleave.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] err_r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), err_r,
           ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
